qpu_dispatch: RTL and testbench
===============================

QPU_DISPATCH -- requirements
Module: qpu_dispatch

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 256, max WAIT-state cycles before abort (range 2..65535).
REQ-002 Parameter: MEAS_CODE, default 6'h3F, gate code identifying a MEASURE instruction.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 quantum_en  input  1  from opcode decoder; current instruction is COP2 (opcode 010010).
REQ-006 instr  input  32  current instruction word.
REQ-007 stall  output  1  freeze PC/pipeline registers.
REQ-008 q_valid  output  1  command valid to QPU.
REQ-009 q_ready  input  1  QPU accepts command.
REQ-010 q_gate  output  6  gate code, latched instr[5:0].
REQ-011 q_target  output  5  target qubit, latched instr[20:16].
REQ-012 q_control  output  5  control qubit, latched instr[15:11].
REQ-013 q_done  input  1  QPU completion pulse.
REQ-014 q_result  input  1  measured bit, valid with q_done.
REQ-015 wb_en  output  1  register-file write strobe.
REQ-016 wb_addr  output  5  destination register, latched instr[25:21].
REQ-017 wb_data  output  32  {31'b0, captured q_result}.
REQ-018 timeout_err  output  1  sticky QPU-timeout flag.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RETIRE; encoding free.
REQ-020 IDLE: quantum_en=1 -> latch instr fields, go ISSUE; else stay.
REQ-021 ISSUE: q_valid=1; q_valid&q_ready on an edge -> go WAIT, clear cycle counter; else hold with fields unchanged.
REQ-022 WAIT: counter increments each cycle; q_done=1 -> capture q_result, go RETIRE.
REQ-023 WAIT: counter reaches TIMEOUT_CYCLES-1 with q_done=0 -> set timeout_err, go RETIRE, no capture.
REQ-024 q_done and timeout in the same cycle: q_done wins, timeout_err unchanged.
REQ-025 RETIRE: single cycle, then IDLE unconditionally; quantum_en ignored in RETIRE.
REQ-026 wb_en=1 only in RETIRE, and only if latched gate==MEAS_CODE and the op completed by q_done (not timeout).
REQ-027 wb_addr/wb_data stable from RETIRE entry until the next ISSUE latch.
REQ-028 stall = (IDLE & quantum_en) | ISSUE | WAIT; combinational; low in RETIRE so the COP2 instruction retires exactly once.
REQ-029 q_valid registered, high only in ISSUE; q_gate/q_target/q_control constant while q_valid=1.
REQ-030 q_done/q_result ignored outside WAIT.
REQ-031 Latency: quantum_en at cycle 0 -> q_valid at cycle 1; q_ready=1 at cycle 1 -> WAIT at cycle 2; q_done at cycle k -> wb_en at cycle k+1.
REQ-032 timeout_err cleared only by reset; further operations proceed normally while set.
REQ-033 Counter width ceil(log2(TIMEOUT_CYCLES)), never wraps (capped by REQ-023).

Reset
REQ-034 rst_n=0 at a clock edge: state IDLE; q_valid, wb_en, timeout_err, counter, latched fields, captured result all 0.
REQ-035 stall = quantum_en during reset (state is IDLE).
REQ-036 Reset mid-ISSUE/WAIT aborts the operation: q_valid low after the edge, no wb_en, later q_done ignored.

Verification
REQ-037 MEASURE: instr=0x4A85_003F (rd=20, target=5), q_ready=1, q_done+q_result=1 three cycles into WAIT -> stall high cycles 0..4, wb_en=1 with wb_addr=20, wb_data=1 in RETIRE, stall low there.
REQ-038 Non-measure gate 6'h01: q_done=1 -> RETIRE with wb_en=0, single dispatch, no re-issue while quantum_en still high in RETIRE.
REQ-039 Backpressure: q_ready low 5 cycles -> q_valid and q_gate/q_target/q_control held 6 cycles, WAIT entered once.
REQ-040 Timeout with TIMEOUT_CYCLES=4, q_done never -> RETIRE after 4 WAIT cycles, timeout_err=1, wb_en=0; next op succeeds with timeout_err still 1.
REQ-041 q_done on the final WAIT cycle -> result written, timeout_err stays 0; q_done pulsed during ISSUE is ignored.
REQ-042 rst_n=0 during WAIT -> all outputs 0 next cycle, subsequent q_done produces no wb_en.

Source files
------------

// File: rtl/qpu_dispatch.sv
// Dispatches COP2 quantum instructions to the QPU, stalls the pipeline until completion or
// timeout, and writes a MEASURE result back to the register file in a single RETIRE cycle.
module qpu_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [5:0]  MEAS_CODE      = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        quantum_en,
  input  logic [31:0] instr,
  output logic        stall,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [5:0]  q_gate,
  output logic [4:0]  q_target,
  output logic [4:0]  q_control,
  input  logic        q_done,
  input  logic        q_result,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETIRE
  } state_e;

  state_e        state_q,   state_d;
  logic [5:0]    gate_q,    gate_d;
  logic [4:0]    target_q,  target_d;
  logic [4:0]    control_q, control_d;
  logic [4:0]    rd_q,      rd_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          res_q,     res_d;
  logic          terr_q,    terr_d;
  logic          q_valid_q, q_valid_d;
  logic          wb_en_q,   wb_en_d;

  // Opcode and shamt fields are decoded upstream; only the operand fields matter here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:26], instr[10:6]};

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    target_d  = target_q;
    control_d = control_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    terr_d    = terr_q;
    q_valid_d = 1'b0;
    wb_en_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (quantum_en) begin
          gate_d    = instr[5:0];
          target_d  = instr[20:16];
          control_d = instr[15:11];
          rd_d      = instr[25:21];
          res_d     = 1'b0;
          q_valid_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (q_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          q_valid_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (q_done) begin
          res_d   = q_result;
          wb_en_d = (gate_q == MEAS_CODE);
          state_d = ST_RETIRE;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_RETIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RETIRE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gate_q    <= '0;
      target_q  <= '0;
      control_q <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      res_q     <= 1'b0;
      terr_q    <= 1'b0;
      q_valid_q <= 1'b0;
      wb_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      target_q  <= target_d;
      control_q <= control_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      terr_q    <= terr_d;
      q_valid_q <= q_valid_d;
      wb_en_q   <= wb_en_d;
    end
  end

  // While rst_n is low the state is about to be IDLE, so behave as IDLE immediately.
  always_comb begin
    if (!rst_n) begin
      stall = quantum_en;
    end else begin
      stall = ((state_q == ST_IDLE) && quantum_en) ||
              (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    end
  end

  assign q_valid     = q_valid_q;
  assign q_gate      = gate_q;
  assign q_target    = target_q;
  assign q_control   = control_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = rd_q;
  assign wb_data     = {31'b0, res_q};
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_qpu_dispatch.sv
// Directed bench for qpu_dispatch with TIMEOUT_CYCLES=4; expected commands and
// writebacks are queued when stimulus is driven and popped when the DUT produces them.
module tb_qpu_dispatch;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, quantum_en, q_ready, q_done, q_result;
  logic [31:0] instr;
  logic        stall, q_valid, wb_en, timeout_err;
  logic [5:0]  q_gate;
  logic [4:0]  q_target, q_control, wb_addr;
  logic [31:0] wb_data;

  qpu_dispatch #(.TIMEOUT_CYCLES(TO), .MEAS_CODE(6'h3F)) dut (
    .clk(clk), .rst_n(rst_n), .quantum_en(quantum_en), .instr(instr),
    .stall(stall), .q_valid(q_valid), .q_ready(q_ready), .q_gate(q_gate),
    .q_target(q_target), .q_control(q_control), .q_done(q_done), .q_result(q_result),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] gate;
    logic [4:0] target;
    logic [4:0] control;
  } cmd_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  cmd_t cmd_q[$];
  wb_t  wb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic terr_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One full operation: IDLE -> ISSUE (rdly stalled cycles) -> WAIT -> RETIRE -> IDLE.
  // ddly < 0 means q_done never arrives and the op must time out.
  task automatic run_op(input logic [31:0] iw, input int rdly, input int ddly,
                        input logic res, input bit hold_en, input bit done_in_issue);
    cmd_t c;
    wb_t  e;
    tick();
    quantum_en = 1'b1; instr = iw; q_ready = 1'b0; q_done = 1'b0; q_result = 1'b0;
    c = '{gate: iw[5:0], target: iw[20:16], control: iw[15:11]};
    cmd_q.push_back(c);
    settle();
    chk("idle_stall", 32'(stall), 32'd1);
    chk("idle_qvalid", 32'(q_valid), 32'd0);

    for (int i = 0; i <= rdly; i++) begin
      tick();
      quantum_en = hold_en; q_ready = (i == rdly);
      q_done = done_in_issue; q_result = done_in_issue;
      settle();
      chk("issue_qvalid", 32'(q_valid), 32'd1);
      chk("issue_stall", 32'(stall), 32'd1);
      chk("issue_cmd", 32'({q_gate, q_target, q_control}), 32'(cmd_q[0]));
    end
    c = cmd_q.pop_front();

    if (ddly >= 0 && ddly < TO) begin
      e = '{en: (iw[5:0] == 6'h3F), addr: iw[25:21], data: {31'b0, res}};
    end else begin
      e = '{en: 1'b0, addr: iw[25:21], data: 32'd0};
      terr_m = 1'b1;
    end
    wb_q.push_back(e);

    for (int w = 0; w < TO; w++) begin
      tick();
      q_ready = 1'b0; q_done = (w == ddly); q_result = res;
      settle();
      chk("wait_qvalid", 32'(q_valid), 32'd0);
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_wben", 32'(wb_en), 32'd0);
      if (w == ddly) break;
    end

    tick();
    q_done = 1'b0; q_result = 1'b0;
    settle();
    e = wb_q.pop_front();
    chk("retire_wben", 32'(wb_en), 32'(e.en));
    chk("retire_wbaddr", 32'(wb_addr), 32'(e.addr));
    chk("retire_wbdata", wb_data, e.data);
    chk("retire_stall", 32'(stall), 32'd0);
    chk("retire_qvalid", 32'(q_valid), 32'd0);
    chk("retire_timeout", 32'(timeout_err), 32'(terr_m));

    tick();
    quantum_en = 1'b0;
    settle();
    chk("post_qvalid", 32'(q_valid), 32'd0);
    chk("post_wben", 32'(wb_en), 32'd0);
    chk("post_wbaddr", 32'(wb_addr), 32'(e.addr));
    chk("post_wbdata", wb_data, e.data);
    chk("post_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; quantum_en = 1'b0; instr = 32'd0;
    q_ready = 1'b0; q_done = 1'b0; q_result = 1'b0;
    tick();
    tick();
    chk("rst_qvalid", 32'(q_valid), 32'd0);
    chk("rst_wben", 32'(wb_en), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_wbaddr", 32'(wb_addr), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_cmd", 32'({q_gate, q_target, q_control}), 32'd0);
    chk("rst_stall_lo", 32'(stall), 32'd0);
    quantum_en = 1'b1;
    settle();
    chk("rst_stall_hi", 32'(stall), 32'd1);
    quantum_en = 1'b0;
    rst_n = 1'b1;

    // MEASURE, rd=20, target=5, done three cycles into WAIT
    run_op(32'h4A85_003F, 0, 2, 1'b1, 1'b0, 1'b0);
    // Non-measure gate with quantum_en held through RETIRE
    run_op({6'h12, 5'd3, 5'd9, 5'd4, 5'd0, 6'h01}, 0, 0, 1'b1, 1'b1, 1'b0);
    // Backpressure: q_ready low for five cycles
    run_op({6'h12, 5'd31, 5'd17, 5'd30, 5'd0, 6'h3F}, 5, 1, 1'b0, 1'b0, 1'b0);
    // Done on final WAIT cycle, with a spurious done during ISSUE
    run_op({6'h12, 5'd7, 5'd2, 5'd1, 5'd0, 6'h3F}, 1, TO - 1, 1'b1, 1'b0, 1'b1);
    // Timeout, then a normal op with the sticky flag still set
    run_op({6'h12, 5'd9, 5'd6, 5'd8, 5'd0, 6'h3F}, 0, -1, 1'b1, 1'b0, 1'b0);
    run_op(32'h4A85_003F, 0, 0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of WAIT
    tick();
    quantum_en = 1'b1; instr = 32'h4A85_003F;
    tick();
    quantum_en = 1'b0; q_ready = 1'b1;
    settle();
    chk("rw_issue_qvalid", 32'(q_valid), 32'd1);
    tick();
    q_ready = 1'b0;
    settle();
    chk("rw_wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; q_done = 1'b1; q_result = 1'b1;
    terr_m = 1'b0;
    settle();
    chk("rw_qvalid", 32'(q_valid), 32'd0);
    chk("rw_wben", 32'(wb_en), 32'd0);
    chk("rw_timeout", 32'(timeout_err), 32'(terr_m));
    chk("rw_wbaddr", 32'(wb_addr), 32'd0);
    chk("rw_wbdata", wb_data, 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    tick();
    q_done = 1'b0; q_result = 1'b0;
    settle();
    chk("rw_late_wben", 32'(wb_en), 32'd0);
    tick();
    chk("rw_late_wben2", 32'(wb_en), 32'd0);
    chk("rw_late_wbdata", wb_data, 32'd0);
    chk("rw_late_qvalid", 32'(q_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
